// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator/checker pair: lock FSM states and
// the default polynomial so both ends of a link agree out of the box.
package lfsr_pkg;

  // Default register length and feedback mask (x^8+x^6+x^5+x^4+1).
  localparam int unsigned LFSR_WIDTH_DEF = 8;
  localparam logic [31:0] LFSR_TAPS_DEF  = 32'h0000_00B8;

  // Checker synchronisation state.
  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-bit predictor for a Fibonacci LFSR: the XOR of all tapped
// state bits. Shared by generator and checker so the polynomial cannot diverge.
module lfsr_next #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
  input  logic [WIDTH-1:0] state_i,
  output logic             pred_o
);

  logic [WIDTH-1:0] tapped;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
      assign tapped[gi] = state_i[gi] & TAPS[gi];
    end
  endgenerate

  assign pred_o = ^tapped;

endmodule

// File: rtl/lfsr_checker.sv
// PRBS receive checker: self-seeds from the incoming stream, declares lock after
// a run of correct predictions, then free-runs its predictor and counts bit
// errors in a saturating counter. Lock is dropped after a run of mispredictions.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH      = LFSR_WIDTH_DEF,
  parameter logic [WIDTH-1:0] TAPS       = LFSR_TAPS_DEF[WIDTH-1:0],
  parameter int unsigned      LOCK_COUNT = 16,
  parameter int unsigned      LOSS_COUNT = 4,
  parameter int unsigned      ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned FILL_W = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(WIDTH);
  localparam logic [7:0]        MATCH_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [3:0]        LOSS_LAST  = 4'(LOSS_COUNT - 1);

  lock_state_e       fsm_q, fsm_d;
  logic [WIDTH-1:0]  state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [7:0]        match_q, match_d;
  logic [3:0]        loss_q, loss_d;
  logic              err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              pred;

  lfsr_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_next (
    .state_i (state_q),
    .pred_o  (pred)
  );

  // Next-state logic: lock FSM, predictor shift, fill/match/loss and error counters.
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    fill_d      = fill_q;
    match_d     = match_q;
    loss_d      = loss_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (bit_valid) begin
      case (fsm_q)
        SEARCH: begin
          // Self-seed from the line; only compare once the register holds WIDTH real bits.
          state_d = {state_q[WIDTH-2:0], bit_in};
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + FILL_W'(1);
          end else if ((bit_in == pred) && (state_q != '0)) begin
            if (match_q == MATCH_LAST) begin
              fsm_d   = LOCKED;
              match_d = '0;
            end else begin
              match_d = match_q + 8'd1;
            end
          end else begin
            // All-zero state is a degenerate fixed point; never let it build lock.
            match_d = '0;
          end
        end
        LOCKED: begin
          // Free-run on our own prediction so a line error cannot corrupt the predictor.
          state_d = {state_q[WIDTH-2:0], pred};
          if (bit_in != pred) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (loss_q == LOSS_LAST) begin
              fsm_d   = SEARCH;
              loss_d  = '0;
              match_d = '0;
              fill_d  = '0;
            end else begin
              loss_d = loss_q + 4'd1;
            end
          end else begin
            loss_d = '0;
          end
        end
        default: fsm_d = SEARCH;
      endcase
    end

    // Clear takes priority over a coincident error increment.
    if (clear_cnt) begin
      err_cnt_d = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= SEARCH;
      state_q     <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      loss_q      <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      loss_q      <= loss_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = (fsm_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: a reference model pushes expected outputs to a queue
// as each input is driven; they are popped and compared one cycle later.
// A second instance with an 8-bit error counter exercises saturation.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst, bit_in, bit_valid, clear_cnt;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        locked_s, err_pulse_s;
  logic [7:0]  err_count_s;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  lfsr_checker #(.ERR_W(8)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear_cnt (clear_cnt),
    .locked    (locked_s),
    .err_pulse (err_pulse_s),
    .err_count (err_count_s)
  );

  typedef struct packed {
    logic        lck;
    logic        pls;
    logic [15:0] cnt;
    logic [7:0]  cnt8;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state
  logic [7:0] m_state;
  int         m_fill, m_match, m_loss, m_err, m_err8;
  logic       m_lock, m_pulse;

  // stream generator
  logic [7:0] g_state;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic b, input logic c);
    logic p;
    if (r) begin
      m_state = '0; m_fill = 0; m_match = 0; m_loss = 0;
      m_lock = 1'b0; m_pulse = 1'b0; m_err = 0; m_err8 = 0;
      return;
    end
    m_pulse = 1'b0;
    if (v) begin
      p = ^(m_state & 8'hB8);
      if (!m_lock) begin
        if (m_fill < 8) m_fill++;
        else if (b == p && m_state != 8'h00) begin
          m_match++;
          if (m_match >= 16) begin
            m_lock  = 1'b1;
            m_match = 0;
          end
        end else m_match = 0;
        m_state = {m_state[6:0], b};
      end else begin
        m_state = {m_state[6:0], p};
        if (b != p) begin
          m_pulse = 1'b1;
          if (m_err < 65535) m_err++;
          if (m_err8 < 255) m_err8++;
          m_loss++;
          if (m_loss >= 4) begin
            m_lock = 1'b0; m_fill = 0; m_match = 0; m_loss = 0;
          end
        end else m_loss = 0;
      end
    end
    if (c) begin
      m_err  = 0;
      m_err8 = 0;
    end
  endtask

  // Drive one cycle of inputs, queue the model's expectation, compare after the edge.
  task automatic step(input logic r, input logic v, input logic b, input logic c);
    exp_t e;
    rst = r; bit_valid = v; bit_in = b; clear_cnt = c;
    model_step(r, v, b, c);
    e.lck  = m_lock;
    e.pls  = m_pulse;
    e.cnt  = 16'(m_err);
    e.cnt8 = 8'(m_err8);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("locked", 32'(locked), 32'(e.lck));
    check_val("err_pulse", 32'(err_pulse), 32'(e.pls));
    check_val("err_count", 32'(err_count), 32'(e.cnt));
    check_val("err_count_sat", 32'(err_count_s), 32'(e.cnt8));
  endtask

  task automatic gen_next(output logic b);
    b = ^(g_state & 8'hB8);
    g_state = {g_state[6:0], b};
  endtask

  function automatic logic next4_ones(input logic [7:0] s);
    logic [7:0] t;
    logic       nb, all;
    t = s;
    all = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nb  = ^(t & 8'hB8);
      all = all & nb;
      t   = {t[6:0], nb};
    end
    return all;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b;
    int   lock_idx, pulses, found, base, seen;

    rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clear_cnt = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_val("rst_locked", 32'(locked), 32'd0);
    check_val("rst_pulse", 32'(err_pulse), 32'd0);
    check_val("rst_count", 32'(err_count), 32'd0);

    // Test 1: clean stream, lock after 8 fill + 16 matches, no errors over 1000 bits
    g_state  = 8'h01;
    lock_idx = 0;
    for (int i = 1; i <= 1000; i++) begin
      gen_next(b);
      step(1'b0, 1'b1, b, 1'b0);
      if (lock_idx == 0 && locked) lock_idx = i;
    end
    check_val("t1_lock_idx", 32'(lock_idx), 32'd24);
    check_val("t1_err_count", 32'(err_count), 32'd0);
    check_val("t1_locked", 32'(locked), 32'd1);

    // Test 2: single flipped bit at index 100
    step(1'b1, 1'b0, 1'b0, 1'b0);
    g_state = 8'h01;
    pulses  = 0;
    for (int i = 1; i <= 300; i++) begin
      gen_next(b);
      if (i == 100) b = ~b;
      step(1'b0, 1'b1, b, 1'b0);
      pulses += int'(err_pulse);
    end
    check_val("t2_pulses", 32'(pulses), 32'd1);
    check_val("t2_err_count", 32'(err_count), 32'd1);
    check_val("t2_locked", 32'(locked), 32'd1);

    // Test 3: four forced zeros where the stream carries four ones -> loss, then relock
    found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      if (next4_ones(g_state)) found = 1;
      else begin
        gen_next(b);
        step(1'b0, 1'b1, b, 1'b0);
      end
    end
    check_val("t3_run_found", 32'(found), 32'd1);
    base = int'(err_count);
    for (int j = 0; j < 4; j++) begin
      gen_next(b);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (j < 3) check_val("t3_hold_lock", 32'(locked), 32'd1);
    end
    check_val("t3_unlocked", 32'(locked), 32'd0);
    check_val("t3_err_plus4", 32'(err_count), 32'(base + 4));
    lock_idx = 0;
    for (int i = 1; i <= 60; i++) begin
      gen_next(b);
      step(1'b0, 1'b1, b, 1'b0);
      if (lock_idx == 0 && locked) lock_idx = i;
    end
    check_val("t3_relock_idx", 32'(lock_idx), 32'd24);
    check_val("t3_err_kept", 32'(err_count), 32'(base + 4));

    // Test 4: stuck-at-0 line never locks
    step(1'b1, 1'b0, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (locked) seen = 1;
    end
    check_val("t4_never_locked", 32'(seen), 32'd0);

    // Test 5: bit_valid one cycle in three
    step(1'b1, 1'b0, 1'b0, 1'b0);
    g_state  = 8'h01;
    lock_idx = 0;
    for (int i = 1; i <= 60; i++) begin
      gen_next(b);
      step(1'b0, 1'b1, b, 1'b0);
      if (lock_idx == 0 && locked) lock_idx = i;
      step(1'b0, 1'b0, 1'($urandom), 1'b0);
      step(1'b0, 1'b0, 1'($urandom), 1'b0);
    end
    check_val("t5_lock_idx", 32'(lock_idx), 32'd24);

    // Test 6: saturation, clear vs coincident error, reset mid-lock
    step(1'b1, 1'b0, 1'b0, 1'b0);
    g_state = 8'h01;
    for (int i = 0; i < 24; i++) begin
      gen_next(b);
      step(1'b0, 1'b1, b, 1'b0);
    end
    check_val("t6_locked", 32'(locked), 32'd1);
    for (int g = 0; g < 90; g++) begin
      for (int j = 0; j < 4; j++) begin
        gen_next(b);
        step(1'b0, 1'b1, (j < 3) ? ~b : b, 1'b0);
      end
    end
    check_val("t6_saturated", 32'(err_count_s), 32'h0000_00FF);
    check_val("t6_wide_count", 32'(err_count), 32'd270);
    check_val("t6_still_locked", 32'(locked), 32'd1);
    gen_next(b);
    step(1'b0, 1'b1, ~b, 1'b1);
    check_val("t6_clear_wins", 32'(err_count), 32'd0);
    check_val("t6_clear_wins_sat", 32'(err_count_s), 32'd0);
    check_val("t6_clear_pulse", 32'(err_pulse), 32'd1);
    gen_next(b);
    step(1'b0, 1'b1, ~b, 1'b0);
    check_val("t6_count_after_clear", 32'(err_count), 32'd1);
    gen_next(b);
    step(1'b1, 1'b1, ~b, 1'b0);
    check_val("t6_rst_locked", 32'(locked), 32'd0);
    check_val("t6_rst_pulse", 32'(err_pulse), 32'd0);
    check_val("t6_rst_count", 32'(err_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
